// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu - rv32i load/store unit
//
// Takes the ALU effective address and runs one data-memory transaction per
// request over a grant/valid handshake. Stores get byte enables and
// lane-replicated data. Loads return sign- or zero-extended data. Misaligned
// accesses and illegal funct3 values finish without a memory access and
// report resp_fault.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/ready           request handshake from the core (ready in IDLE)
//   req_store, req_funct3     operation kind (RV32I funct3 encoding)
//   req_addr, req_wdata       effective byte address and store data (rs2)
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_fault    extended load data (0 for stores/faults), fault
//   mem_req/we/addr/be/wdata  memory request, held stable until mem_gnt
//   mem_gnt                   memory accepted the request
//   mem_rvalid, mem_rdata     load data return
// ----------------------------------------------------------------------------
module lsu #(
  parameter int DataWidth = 32,  // OperandSize; only 32 is supported
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [2:0]           req_funct3,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [DataWidth-1:0] resp_rdata,
  output logic                 resp_fault,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DataWidth-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Misaligned halfword/word or a funct3 outside the legal load/store set.
  function automatic logic is_fault(input logic store, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic legal;
    logic misaligned;
    case (f3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = 1'b1;
      3'b010:  legal = 1'b1;
      3'b100:  legal = ~store;
      3'b101:  legal = ~store;
      default: legal = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return ~legal | misaligned;
  endfunction

  // Byte enables; loads always read the full word.
  function automatic logic [3:0] calc_be(input logic store, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [3:0] be;
    if (store) begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = 4'b0011 << {off[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Replicate the store data into every lane so the enables pick the target.
  function automatic logic [31:0] calc_wdata(input logic store, input logic [2:0] f3,
                                             input logic [31:0] wd);
    logic [31:0] res;
    if (store) begin
      case (f3[1:0])
        2'b00:   res = {4{wd[7:0]}};
        2'b01:   res = {2{wd[15:0]}};
        default: res = wd;
      endcase
    end else begin
      res = 32'h0000_0000;
    end
    return res;
  endfunction

  // Pick the addressed lane from the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'h00_0000, b};
      3'b101:  res = {16'h0000, h};
      default: res = word;
    endcase
    return res;
  endfunction

  state_e                 state_q, state_d;
  logic                   store_q, store_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             off_q, off_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic [DataWidth-1:0]   mem_wdata_q, mem_wdata_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0]   resp_rdata_q, resp_rdata_d;
  logic                   resp_fault_q, resp_fault_d;
  logic                   fault_s;

  // Fault classification of the request currently presented.
  always_comb begin
    fault_s = is_fault(req_store, req_funct3, req_addr[1:0]);
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d      = req_store;
          funct3_d     = req_funct3;
          off_d        = req_addr[1:0];
          mem_addr_d   = {req_addr[AddrWidth-1:2], 2'b00};
          mem_be_d     = calc_be(req_store, req_funct3, req_addr[1:0]);
          mem_wdata_d  = calc_wdata(req_store, req_funct3, req_wdata);
          resp_rdata_d = '0;
          resp_fault_d = fault_s;
          if (fault_s) begin
            // Faulting ops never reach memory.
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            mem_req_d = 1'b1;
            mem_we_d  = req_store;
            state_d   = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (store_q) begin
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          resp_rdata_d = load_extract(funct3_q, off_q, mem_rdata);
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Ready only in IDLE and never while reset is asserted.
  assign req_ready  = (state_q == IDLE) & ~rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu - self-checking bench for lsu. Expected responses are pushed to a
// scoreboard queue when a request is driven and popped when resp_valid fires.
// ----------------------------------------------------------------------------
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else pass_cnt++;
  endtask

  // Drive one request, play the memory side, and score the response.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                        input bit stray, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] erd, input logic eflt);
    exp_t e;
    exp_t got;
    int   cyc;
    int   waited;
    bit   pend_rv;
    bit   done;
    e.rdata = erd;
    e.fault = eflt;
    e.lat   = eflt ? 1 : (st ? 2 + dly : 3 + dly);
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; waited = 0; pend_rv = 1'b0; done = 1'b0;
    while (!done && cyc <= 20) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (cyc == 1) check_eq("req_ready_busy", req_ready, 1'b0);
      if (eflt) check_eq("fault_no_mem_req", mem_req, 1'b0);
      if (resp_valid) begin
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check_eq("resp_fault", resp_fault, got.fault);
          check_eq("resp_rdata", resp_rdata, got.rdata);
          check_eq("resp_latency", cyc, got.lat);
        end else begin
          check_eq("sb_empty", 0, 1);
        end
        done = 1'b1;
      end else if (mem_req) begin
        check_eq("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check_eq("mem_be", mem_be, ebe);
        check_eq("mem_we", mem_we, st);
        if (st) check_eq("mem_wdata", mem_wdata, ewd);
        if (waited >= dly) begin
          mem_gnt = 1'b1;
          pend_rv = ~st;
        end else begin
          waited++;
          if (stray && waited == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h5555_5555;
          end
        end
      end else if (pend_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        pend_rv    = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!done) check_eq("resp_timeout", cyc, e.lat);
    check_eq("resp_pulse", resp_valid, 1'b0);
    check_eq("req_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("req_ready_after_rst", req_ready, 1'b1);

    //     st    f3      addr          wdata         rdata         dly stray be       ewd           erd           flt
    run_op(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0);
    run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0);
    run_op(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 1'b0, 4'b1111, 32'h0,        32'h0000_0080, 1'b0);
    run_op(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8011_2233, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFF_8011, 1'b0);
    run_op(1'b0, 3'b101, 32'h0000_0000, 32'h0,        32'h1234_ABCD, 0, 1'b0, 4'b1111, 32'h0,        32'h0000_ABCD, 1'b0);
    run_op(1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1, 1'b0, 4'b1111, 32'h0,        32'h0000_007F, 1'b0);
    run_op(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0,       0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0);
    run_op(1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0,       0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0);
    run_op(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,       0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0);
    run_op(1'b1, 3'b010, 32'h0000_0302, 32'h1111_1111, 32'h0,       0, 1'b0, 4'b1111, 32'h0,        32'h0,        1'b1);
    run_op(1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b0, 4'b1111, 32'h0,        32'h0,        1'b1);
    run_op(1'b1, 3'b011, 32'h0000_0300, 32'h2222_2222, 32'h0,       0, 1'b0, 4'b1111, 32'h0,        32'h0,        1'b1);
    run_op(1'b0, 3'b110, 32'h0000_0300, 32'h0,        32'h0,        0, 1'b0, 4'b1111, 32'h0,        32'h0,        1'b1);
    run_op(1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h0BAD_F00D, 3, 1'b1, 4'b1111, 32'h0,       32'h0BAD_F00D, 1'b0);
    run_op(1'b1, 3'b000, 32'h0000_0003, 32'h0000_005A, 32'h0,       2, 1'b0, 4'b1000, 32'h5A5A_5A5A, 32'h0,        1'b0);

    // Reset while waiting for load data: transaction abandoned, late rvalid ignored.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0500;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_mem_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_mem_req_drop", mem_req, 1'b0);
    check_eq("abort_resp_valid", resp_valid, 1'b0);
    check_eq("abort_mem_addr", mem_addr, 32'h0);
    check_eq("abort_mem_be", mem_be, 4'b0000);
    check_eq("abort_mem_wdata", mem_wdata, 32'h0);
    check_eq("abort_resp_rdata", resp_rdata, 32'h0);
    check_eq("abort_resp_fault", resp_fault, 1'b0);
    check_eq("abort_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("abort_idle_ready", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("abort_no_resp", resp_valid, 1'b0);
      @(negedge clk);
    end
    check_eq("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the rv32i execute/memory path, directly downstream of the ALU. It takes the ALU `SUM` result as an effective address and performs one data-memory transaction per request over a grant/valid memory handshake. It generates byte enables and lane-replicated write data for SB/SH/SW, and returns sign- or zero-extended load data for LB/LH/LW/LBU/LHU. Misaligned or illegal accesses complete without touching memory and raise a fault flag.

## Interface

Parameters:
- `DataWidth`, default `OperandSize` (32): data path width; only 32 is supported.
- `AddrWidth`, default 32: byte address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  core presents a memory op.
- `req_ready`  out  1  LSU accepts a request (high only in IDLE).
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `req_addr`  in  AddrWidth  effective byte address (ALU result).
- `req_wdata`  in  DataWidth  store data (rs2).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  DataWidth  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  misaligned or illegal funct3; valid with `resp_valid`.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  AddrWidth  word address; `req_addr` with bits [1:0] forced to 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  DataWidth  lane-replicated store data.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  DataWidth  full 32-bit word read.

## Operation

- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch store, funct3, addr and wdata.
  - Fault check:
    - Halfword with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
    - funct3 not listed above is illegal; this includes store funct3 ≥ 011.
  - Fault → RESP. No fault → REQ.
- REQ:
  - `mem_req`=1. `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` are driven from registers and held stable until `mem_gnt`.
  - On `mem_gnt`: store → RESP; load → WAIT.
- WAIT:
  - On `mem_rvalid`, extract the lane and extend, register the result into `resp_rdata`, → RESP.
  - `mem_rvalid` in any state other than WAIT is ignored.
- RESP: `resp_valid`=1 for exactly one cycle → IDLE.
- Byte enables and store data (o = addr[1:0]):
  - SB: `mem_be`=0001<<o; `mem_wdata`={4{wdata[7:0]}}.
  - SH: `mem_be`=0011<<(2·addr[1]); `mem_wdata`={2{wdata[15:0]}}.
  - SW: `mem_be`=1111; `mem_wdata`=wdata.
  - Loads: `mem_be`=1111.
- Load extraction:
  - LB/LBU: byte `mem_rdata[8o+7:8o]`.
  - LH/LHU: half `mem_rdata[16·addr[1]+15:16·addr[1]]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

## Timing

- Reset:
  - State IDLE.
  - `mem_req`, `mem_we`, `resp_valid`, `resp_fault` = 0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `resp_rdata` = 0.
  - `req_ready`=0 while `rst` is high, 1 in the first cycle after.
- Accept at cycle 0; best case is `mem_gnt` immediate and `rvalid` the cycle after the grant:
  - load: REQ at c1, WAIT at c2, `resp_valid` at c3.
  - store: REQ at c1, `resp_valid` at c2.
  - fault: `resp_valid` at c1.
- Each cycle without `mem_gnt` or `mem_rvalid` adds one cycle.
- One outstanding request. `req_ready`=0 from the cycle after accept through RESP, so the next accept is earliest in the cycle after `resp_valid`.
- `resp_rdata` and `resp_fault` hold until the next accept; they are meaningful only while `resp_valid`=1.
- Reset mid-operation: the transaction is abandoned, `mem_req` drops the next cycle, and no `resp_valid` is issued. A later `mem_rvalid` arriving in IDLE is ignored.
- `mem_gnt` while `mem_req`=0 is ignored.

## Test plan

- LW, addr 0x100, gnt immediate, rdata 0xDEADBEEF next cycle → `mem_addr`=0x100, `mem_be`=1111; `resp_valid` at c3 with `resp_rdata`=0xDEADBEEF, `resp_fault`=0.
- LB vs LBU, addr 0x103, rdata 0x80112233 → LB returns 0xFFFFFF80; LBU returns 0x00000080. LH at 0x102 returns 0xFFFF8011.
- SB, addr 0x201, wdata 0x000000A5 → `mem_we`=1, `mem_addr`=0x200, `mem_be`=0010, `mem_wdata`=0xA5A5A5A5; `resp_valid` at c2, `resp_rdata`=0.
- SW at 0x302 and LH at 0x101 → `mem_req` stays 0; `resp_valid`+`resp_fault`=1 at c1. Store funct3 011 also faults.
- LW with `mem_gnt` held low 3 cycles → address and enables stable throughout; `resp_valid` at c6. A stray `mem_rvalid` during REQ is ignored.
- `rst` asserted while in WAIT → next cycle IDLE, all outputs 0, no `resp_valid`. A `mem_rvalid` arriving afterwards produces no response.
